fp_unit_arbiter: RTL and testbench

//  Shares one fp_unit execute port (fp_exe_i/fp_exe_o) among NREQ requesters (e.g. integer pipe, vector lane, test bench).

---
 rtl/fp_unit_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_fp_unit_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter
//   Shares one fp_unit execute port among NREQ requesters. Round-robin grant,
//   one operation outstanding at a time, result/flags captured and returned to
//   the granted requester. A watchdog aborts an operation whose completion
//   never arrives and returns a zero result tagged rsp_timeout.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (req_ready one-hot)
//   req_data1/2/3          per-requester operands, slice i = [64*i +: 64]
//   req_fmt/req_rm/req_op  per-requester format (2b), rounding mode (3b), op
//   rsp_valid/rsp_ready    per-requester response handshake (rsp_valid one-hot)
//   rsp_result/flags       captured result and NV,DZ,OF,UF,NX flags
//   rsp_timeout            response belongs to an aborted operation
//   fpu_*                  fp_unit execute port (operands/enable out, result in)

package fp_unit_arbiter_pkg;

  // Operation selector carried on the fp_unit execute port.
  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

endpackage

module fp_unit_arbiter
  import fp_unit_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_data1,
  input  logic [NREQ*64-1:0]   req_data2,
  input  logic [NREQ*64-1:0]   req_data3,
  input  logic [NREQ*2-1:0]    req_fmt,
  input  logic [NREQ*3-1:0]    req_rm,
  input  fp_operation_type     req_op [NREQ],
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 rsp_timeout,
  output logic [63:0]          fpu_data1,
  output logic [63:0]          fpu_data2,
  output logic [63:0]          fpu_data3,
  output logic [1:0]           fpu_fmt,
  output logic [2:0]           fpu_rm,
  output fp_operation_type     fpu_op,
  output logic                 fpu_enable,
  input  logic [63:0]          fpu_result,
  input  logic [4:0]           fpu_flags,
  input  logic                 fpu_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    rr_ptr, rr_next;
  logic [PW-1:0]    grant, grant_next;
  logic [WW-1:0]    wdog, wdog_next;

  logic [63:0]      d1_next, d2_next, d3_next;
  logic [1:0]       fmt_next;
  logic [2:0]       rm_next;
  fp_operation_type op_next;
  logic             enable_next;
  logic [63:0]      result_next;
  logic [4:0]       flags_next;
  logic             timeout_next;

  // Round-robin search: first valid requester starting at rr_ptr.
  logic             found;
  logic [PW-1:0]    pick;
  int unsigned      scan_idx;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && req_valid[PW'(scan_idx)]) begin
        found = 1'b1;
        pick  = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_next   = state;
    rr_next      = rr_ptr;
    grant_next   = grant;
    wdog_next    = wdog;
    d1_next      = fpu_data1;
    d2_next      = fpu_data2;
    d3_next      = fpu_data3;
    fmt_next     = fpu_fmt;
    rm_next      = fpu_rm;
    op_next      = fpu_op;
    enable_next  = 1'b0;
    result_next  = rsp_result;
    flags_next   = rsp_flags;
    timeout_next = rsp_timeout;
    req_ready    = '0;
    rsp_valid    = '0;

    case (state)
      IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          grant_next      = pick;
          d1_next         = req_data1[64*int'(pick) +: 64];
          d2_next         = req_data2[64*int'(pick) +: 64];
          d3_next         = req_data3[64*int'(pick) +: 64];
          fmt_next        = req_fmt[2*int'(pick) +: 2];
          rm_next         = req_rm[3*int'(pick) +: 3];
          op_next         = req_op[pick];
          // Enable is registered, so it is raised on the accept edge to be
          // visible exactly during ISSUE.
          enable_next     = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        wdog_next  = '0;
        op_next    = init_fp_operation;
        state_next = WAIT;
      end
      WAIT: begin
        if (fpu_ready) begin
          result_next  = fpu_result;
          flags_next   = fpu_flags;
          timeout_next = 1'b0;
          state_next   = RESP;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          result_next  = '0;
          flags_next   = '0;
          timeout_next = 1'b1;
          state_next   = RESP;
        end else begin
          wdog_next = wdog + 1'b1;
        end
      end
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          rr_next    = (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      wdog        <= '0;
      fpu_data1   <= '0;
      fpu_data2   <= '0;
      fpu_data3   <= '0;
      fpu_fmt     <= '0;
      fpu_rm      <= '0;
      fpu_op      <= init_fp_operation;
      fpu_enable  <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_next;
      grant       <= grant_next;
      wdog        <= wdog_next;
      fpu_data1   <= d1_next;
      fpu_data2   <= d2_next;
      fpu_data3   <= d3_next;
      fpu_fmt     <= fmt_next;
      fpu_rm      <= rm_next;
      fpu_op      <= op_next;
      fpu_enable  <= enable_next;
      rsp_result  <= result_next;
      rsp_flags   <= flags_next;
      rsp_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter
//   Directed bench for fp_unit_arbiter with a transaction-timeline model of the
//   arbiter and a scripted stand-in for the fp_unit (configurable latency,
//   optional stray ready pulse).
module tb_fp_unit_arbiter;
  import fp_unit_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*64-1:0]   req_data1, req_data2, req_data3;
  logic [NREQ*2-1:0]    req_fmt;
  logic [NREQ*3-1:0]    req_rm;
  fp_operation_type     req_op [NREQ];
  logic [63:0]          rsp_result, fpu_data1, fpu_data2, fpu_data3, fpu_result;
  logic [4:0]           rsp_flags, fpu_flags;
  logic                 rsp_timeout, fpu_enable, fpu_ready;
  logic [1:0]           fpu_fmt;
  logic [2:0]           fpu_rm;
  fp_operation_type     fpu_op;

  fp_unit_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .fpu_data1(fpu_data1), .fpu_data2(fpu_data2), .fpu_data3(fpu_data3),
    .fpu_fmt(fpu_fmt), .fpu_rm(fpu_rm), .fpu_op(fpu_op), .fpu_enable(fpu_enable),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- fp_unit stand-in ----------------
  int          fpu_lat  = 1;   // cycles from enable to ready; 0 = never
  logic [63:0] fake_res = '0;
  logic [4:0]  fake_flg = '0;
  bit          stray    = 1'b0;
  int          pend     = 0;

  initial begin
    fpu_ready  = 1'b0;
    fpu_result = '0;
    fpu_flags  = '0;
    forever begin
      @(negedge clock);
      if (!reset) pend = 0;
      else if (fpu_enable && fpu_lat > 0) pend = fpu_lat;
      @(posedge clock);
      #2;
      fpu_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpu_ready  = 1'b1;
          fpu_result = fake_res;
          fpu_flags  = fake_flg;
        end
      end
      if (stray) begin
        fpu_ready  = 1'b1;
        fpu_result = '1;
        fpu_flags  = '1;
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  // The model tracks one transaction as a timeline relative to its accept
  // cycle: enable one cycle later, completion on the first fpu_ready from two
  // cycles later (or after TIMEOUT waiting cycles), response from the next.
  bit               m_busy = 0, m_done = 0, m_after_reset = 0;
  int               m_tacc, m_grant, m_rr = 0;
  logic [63:0]      m_d1, m_d2, m_d3, m_res;
  logic [1:0]       m_fmt;
  logic [2:0]       m_rm;
  fp_operation_type m_op;
  logic [4:0]       m_flg;
  bit               m_to;

  int enable_cnt = 0, last_en_cyc = 0, rv_total = 0;
  int rv_cnt [NREQ] = '{default: 0};
  int grant_log [$];

  logic [NREQ-1:0]  exp_rr, exp_rv;
  logic             exp_en;
  fp_operation_type exp_op;
  int               win, kk;

  always @(negedge clock) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_rr = 0; m_after_reset = 1;
    end else begin
      exp_rr = '0; exp_rv = '0; exp_en = 1'b0; exp_op = init_fp_operation;
      if (m_after_reset) begin
        check("reset_data1", fpu_data1, 0);
        check("reset_data2", fpu_data2, 0);
        check("reset_data3", fpu_data3, 0);
        check("reset_fmt_rm", {fpu_fmt, fpu_rm}, 0);
        check("reset_result", rsp_result, 0);
        check("reset_flags", rsp_flags, 0);
        check("reset_timeout", rsp_timeout, 0);
        m_after_reset = 0;
      end
      if (!m_busy) begin
        win = -1;
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
        if (win >= 0) begin
          exp_rr[win] = 1'b1;
          m_busy = 1; m_done = 0; m_tacc = cyc; m_grant = win;
          m_d1 = req_data1[64*win +: 64];
          m_d2 = req_data2[64*win +: 64];
          m_d3 = req_data3[64*win +: 64];
          m_fmt = req_fmt[2*win +: 2];
          m_rm  = req_rm[3*win +: 3];
          m_op  = req_op[win];
          grant_log.push_back(win);
        end
      end else begin
        kk = cyc - m_tacc;
        if (kk == 1) begin
          exp_en = 1'b1;
          exp_op = m_op;
          check("issue_data1", fpu_data1, m_d1);
          check("issue_data2", fpu_data2, m_d2);
          check("issue_data3", fpu_data3, m_d3);
          check("issue_fmt", fpu_fmt, m_fmt);
          check("issue_rm", fpu_rm, m_rm);
        end else if (!m_done) begin
          if (fpu_ready) begin
            m_done = 1; m_res = fpu_result; m_flg = fpu_flags; m_to = 0;
          end else if (kk - 2 == TIMEOUT - 1) begin
            m_done = 1; m_res = '0; m_flg = '0; m_to = 1;
          end
        end else begin
          exp_rv[m_grant] = 1'b1;
          check("rsp_result", rsp_result, m_res);
          check("rsp_flags", rsp_flags, m_flg);
          check("rsp_timeout", rsp_timeout, m_to);
          if (rsp_ready[m_grant]) begin
            m_busy = 0;
            m_rr = (m_grant + 1) % NREQ;
          end
        end
      end
      check("req_ready", req_ready, exp_rr);
      check("rsp_valid", rsp_valid, exp_rv);
      check("fpu_enable", fpu_enable, exp_en);
      check("fpu_op", 64'(fpu_op), 64'(exp_op));

      if (fpu_enable) begin enable_cnt++; last_en_cyc = cyc; end
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) begin rv_cnt[i]++; rv_total++; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [1:0] f, input logic [2:0] r,
                         input fp_operation_type o);
    req_data1[64*i +: 64] = a;
    req_data2[64*i +: 64] = b;
    req_data3[64*i +: 64] = c;
    req_fmt[2*i +: 2]     = f;
    req_rm[3*i +: 3]      = r;
    req_op[i]             = o;
  endtask

  // Waits (bounded) for requester i to be accepted; returns at that negedge.
  task automatic wait_accept(input int i, output int t);
    bit got = 0;
    t = 0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clock);
      if (req_ready[i]) begin got = 1; t = cyc; end
    end
    if (!got) check("accept_bound", 0, 1);
  endtask

  task automatic wait_rsp(output int c);
    bit got = 0;
    c = 0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin got = 1; c = cyc; end
    end
    if (!got) check("rsp_bound", 0, 1);
  endtask

  fp_operation_type op_add, op_mul, op_div;
  int t, c, t2, e0, r0, g;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b0; req_valid = '0; rsp_ready = '1;
    req_data1 = '0; req_data2 = '0; req_data3 = '0; req_fmt = '0; req_rm = '0;
    for (int i = 0; i < NREQ; i++) req_op[i] = init_fp_operation;
    op_add = init_fp_operation; op_add.fadd = 1'b1;
    op_mul = init_fp_operation; op_mul.fmul = 1'b1;
    op_div = init_fp_operation; op_div.fdiv = 1'b1;
    repeat (3) tick();
    reset = 1'b1;

    // 1: single f32 add, ready one cycle after enable
    set_req(0, 64'h3F800000, 64'h40000000, 64'h0, 2'd0, 3'd0, op_add);
    fake_res = 64'h40400000; fake_flg = 5'h00; fpu_lat = 1; e0 = enable_cnt;
    req_valid = 4'b0001;
    wait_accept(0, t);
    tick(); req_valid = '0;
    wait_rsp(c);
    check("t1_latency", c - t, 3);
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_result", rsp_result, 64'h40400000);
    check("t1_flags", rsp_flags, 5'h00);
    tick(); tick();
    check("t1_enable_cycles", enable_cnt - e0, 1);

    // 2: round robin from a fresh pointer, all requesters pending
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 64'h100 + 64'(i), 64'h200 + 64'(i), 64'h300 + 64'(i), 2'(i % 2), 3'(i),
              (i % 2 == 0) ? op_mul : op_div);
    grant_log.delete();
    fake_res = 64'h3FF0000000000000; fake_flg = 5'h01;
    req_valid = '1;
    for (int w = 0; w < 200 && grant_log.size() < 5; w++) tick();
    req_valid = '0;
    repeat (8) tick();
    check("t2_grant_count", (grant_log.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : -1;
      check("t2_grant_order", g, exp_order[i]);
    end

    // 3: completion never arrives -> watchdog abort
    fpu_lat = 0;
    req_valid = 4'b0010;
    wait_accept(1, t);
    tick(); req_valid = '0;
    wait_rsp(c);
    check("t3_enable_to_rsp", c - last_en_cyc, 65);
    check("t3_rsp_valid", rsp_valid, 4'b0010);
    check("t3_timeout", rsp_timeout, 1);
    check("t3_result", rsp_result, 0);
    check("t3_flags", rsp_flags, 0);
    tick(); tick();

    // 4: backpressure by the granted requester only; others' rsp_ready ignored
    fpu_lat = 2; fake_res = 64'h1234; fake_flg = 5'h01;
    rsp_ready = 4'b1011; r0 = rv_cnt[2];
    req_valid = 4'b0100;
    wait_accept(2, t);
    tick(); req_valid = 4'b0001;
    wait_rsp(c);
    repeat (10) tick();
    rsp_ready = '1;
    wait_accept(0, t2);
    check("t4_next_accept", t2 - c, 11);
    tick(); req_valid = '0;
    wait_rsp(c);
    tick(); tick();
    check("t4_held_cycles", rv_cnt[2] - r0, 11);
    check("t4_held_result", (rv_cnt[2] - r0 == 11) ? 64'h1234 : 64'h0, 64'h1234);

    // 5: ready on the last watchdog cycle wins over abort
    fpu_lat = 64; fake_res = 64'h7FC00000; fake_flg = 5'h10;
    req_valid = 4'b1000;
    wait_accept(3, t);
    tick(); req_valid = '0;
    wait_rsp(c);
    check("t5_latency", c - t, 66);
    check("t5_timeout", rsp_timeout, 0);
    check("t5_result", rsp_result, 64'h7FC00000);
    check("t5_flags", rsp_flags, 5'h10);
    tick(); tick();

    // 6: reset while waiting; stray ready afterwards is ignored
    fpu_lat = 0;
    req_valid = 4'b0001;
    wait_accept(0, t);
    tick(); req_valid = '0;
    repeat (5) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    stray = 1'b1; r0 = rv_total;
    tick(); stray = 1'b0;
    repeat (5) tick();
    check("t6_no_rsp", rv_total - r0, 0);
    check("t6_result", rsp_result, 0);
    check("t6_enable", fpu_enable, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
